// File: rtl/auc_ram_arb.sv
// Round-robin arbiter sharing the ECC operand RAM between NREQ requesters.
// Grants one access per cycle, supports ownership locks, and tags read data one-hot.
module auc_ram_arb #(
    parameter int WIDTH = 256,
    parameter int ADDR  = 5,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         arb_req,
    input  logic [NREQ-1:0]         arb_we,
    input  logic [NREQ-1:0]         arb_lock,
    input  logic [NREQ*ADDR-1:0]    arb_addr,
    input  logic [NREQ*WIDTH-1:0]   arb_wdat,
    output logic [NREQ-1:0]         arb_gnt,
    output logic [NREQ-1:0]         arb_rvld,
    output logic [WIDTH-1:0]        arb_rdat,
    output logic                    arb_busy,
    output logic [ADDR-1:0]         ram_radd,
    input  logic [WIDTH-1:0]        ram_rdat,
    output logic                    ram_wen,
    output logic [ADDR-1:0]         ram_wadd,
    output logic [WIDTH-1:0]        ram_wdat
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]   r_rr_ptr;
    logic             r_own_vld;
    logic [IDW-1:0]   r_own_id;
    logic [NREQ-1:0]  r_pend1;
    logic [NREQ-1:0]  r_pend2;
    logic             r_wen;
    logic [ADDR-1:0]  r_radd;
    logic [ADDR-1:0]  r_wadd;
    logic [WIDTH-1:0] r_wdat;

    logic             w_gnt_vld;
    logic [IDW-1:0]   w_gnt_id;
    logic [NREQ-1:0]  w_gnt;
    logic [ADDR-1:0]  w_addr;
    logic [WIDTH-1:0] w_wdat;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
        return IDW'((int'(base) + off) % NREQ);
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_gnt     = '0;
        if (r_own_vld) begin
            if (arb_req[r_own_id]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = r_own_id;
            end
        end else begin
            // Scan farthest-first so the nearest requester after rr_ptr overrides.
            for (int k = NREQ; k >= 1; k--) begin
                if (arb_req[rr_idx(r_rr_ptr, k)]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_id  = rr_idx(r_rr_ptr, k);
                end
            end
        end
        if (rst) begin
            w_gnt_vld = 1'b0;
        end
        if (w_gnt_vld) begin
            w_gnt[w_gnt_id] = 1'b1;
        end
    end

    assign w_addr = arb_addr[w_gnt_id*ADDR +: ADDR];
    assign w_wdat = arb_wdat[w_gnt_id*WIDTH +: WIDTH];

    // NOTE: sequential state uses non-blocking assignments only; the data registers
    // are reset too because their reset value is visible on the RAM ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= IDW'(NREQ - 1);
            r_own_vld <= 1'b0;
            r_own_id  <= '0;
            r_pend1   <= '0;
            r_pend2   <= '0;
            r_wen     <= 1'b0;
            r_radd    <= '0;
            r_wadd    <= '0;
            r_wdat    <= '0;
        end else begin
            r_wen   <= 1'b0;
            r_pend1 <= '0;
            r_pend2 <= r_pend1;
            if (w_gnt_vld) begin
                r_rr_ptr <= w_gnt_id;
                if (arb_we[w_gnt_id]) begin
                    r_wen  <= 1'b1;
                    r_wadd <= w_addr;
                    r_wdat <= w_wdat;
                end else begin
                    r_radd  <= w_addr;
                    r_pend1 <= w_gnt;
                end
                if (arb_lock[w_gnt_id] && !r_own_vld) begin
                    r_own_vld <= 1'b1;
                    r_own_id  <= w_gnt_id;
                end
            end
            // Release cycle stays owner-only; ownership ends at this edge.
            if (r_own_vld && !arb_lock[r_own_id]) begin
                r_own_vld <= 1'b0;
            end
        end
    end

    assign arb_gnt  = w_gnt;
    assign arb_rvld = r_pend2;
    assign arb_rdat = ram_rdat;
    assign arb_busy = r_own_vld;
    assign ram_radd = r_radd;
    assign ram_wen  = r_wen;
    assign ram_wadd = r_wadd;
    assign ram_wdat = r_wdat;

endmodule
